// File: rtl/imm_pack_pkg.sv
// imm_pack_pkg: imm_src format codes, per-format field masks and the packed-result record
package imm_pack_pkg;

    typedef enum logic [2:0] {
        IMM_I  = 3'b000,
        IMM_U  = 3'b001,
        IMM_S  = 3'b010,
        IMM_SH = 3'b011,
        IMM_J  = 3'b100
    } imm_src_e;

    localparam logic [24:0] IMM_MASK_I  = 25'h1FFF000;
    localparam logic [24:0] IMM_MASK_U  = 25'h1FFFFC0;
    localparam logic [24:0] IMM_MASK_S  = 25'h1FC003F;
    localparam logic [24:0] IMM_MASK_SH = 25'h1FFF03F;
    localparam logic [24:0] IMM_MASK_J  = 25'h1FFFFC0;

    typedef struct packed {
        logic [24:0] field;
        logic [24:0] mask;
        logic        err;
    } packed_imm_t;

    // True when v[31:b] are all copies of v[b], i.e. v sign-extends from bit b
    function automatic logic fits(input logic [31:0] v, input int b);
        logic [31:0] t;
        t = $signed(v) >>> b;
        return (t == '0) || (t == '1);
    endfunction

endpackage

// File: rtl/imm_pack_field.sv
// imm_field_pack: combinational (src, v, w) -> (field, mask, err) immediate packer
module imm_field_pack
    import imm_pack_pkg::*;
(
    input  logic [2:0]  src,
    input  logic [31:0] v,
    input  logic [31:0] w,
    output logic [24:0] field,
    output logic [24:0] mask,
    output logic        err
);

    always_comb begin
        field = '0;
        mask  = '0;
        err   = 1'b1;
        case (src)
            IMM_I: begin
                field = {v[12:0], 12'b0};
                mask  = IMM_MASK_I;
                err   = !fits(v, 12);
            end
            IMM_U: begin
                field = {v[31:13], 6'b0};
                mask  = IMM_MASK_U;
                err   = v[12:0] != '0;
            end
            IMM_S: begin
                field = {v[12:6], 12'b0, v[5:0]};
                mask  = IMM_MASK_S;
                err   = !fits(v, 12);
            end
            IMM_SH: begin
                field = {w[12:6], v[5:0], 6'b0, w[5:0]};
                mask  = IMM_MASK_SH;
                err   = !fits(v, 5) || !fits(w, 12);
            end
            IMM_J: begin
                field = {v[18:0], 6'b0};
                mask  = IMM_MASK_J;
                err   = !fits(v, 18);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/imm_pack.sv
// imm_pack: two-stage valid/ready pipeline packing 32-bit immediates into the 25-bit instruction field
module imm_pack
    import imm_pack_pkg::*;
#(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_src,
    input  logic [31:0]          in_val,
    input  logic [31:0]          in_val2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [24:0]          imm_field,
    output logic [24:0]          imm_mask,
    output logic                 range_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic [24:0] pk_field, pk_mask;
    logic        pk_err;
    packed_imm_t pk, s1_q, s1_d, s2_q, s2_d;
    logic        s1_valid_q, s1_valid_d, out_valid_q, out_valid_d, s2_adv;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    imm_field_pack u_pack (
        .src   (in_src),
        .v     (in_val),
        .w     (in_val2),
        .field (pk_field),
        .mask  (pk_mask),
        .err   (pk_err)
    );

    // Ready is masked during reset so no handshake can complete in that cycle
    always_comb begin
        pk          = '{field: pk_field, mask: pk_mask, err: pk_err};
        s2_adv      = !out_valid_q || out_ready;
        in_ready    = !rst && (!s1_valid_q || s2_adv);
        s1_valid_d  = in_ready ? in_valid : s1_valid_q;
        s1_d        = (in_ready && in_valid) ? pk : s1_q;
        out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
        s2_d        = (s2_adv && s1_valid_q) ? s1_q : s2_q;
        err_cnt_d   = err_cnt_q + ERR_CNT_W'(out_valid_q && out_ready && s2_q.err && !(&err_cnt_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            s1_q        <= '0;
            s2_q        <= '0;
            err_cnt_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_valid = out_valid_q && !rst;
    assign imm_field = s2_q.field;
    assign imm_mask  = s2_q.mask;
    assign range_err = s2_q.err;
    assign err_cnt   = err_cnt_q;

endmodule
